// File: rtl/pong_ball_engine.sv
// Pong ball engine: serve/play/score sequencing, paddle and wall bounces, and ball render.
// Game state advances only on the frame tick (last active pixel of the frame).
module pong_ball_engine #(
    parameter int H_RES            = 640,
    parameter int V_RES            = 480,
    parameter int BALL_W           = 8,
    parameter int BALL_H           = 8,
    parameter int PAD_W            = 10,
    parameter int PAD_H            = 90,
    parameter int PAD1_X           = 10,
    parameter int PAD2_X           = 620,
    parameter int STEP_X           = 2,
    parameter int STEP_X_MAX       = 6,
    parameter int DY_MAX           = 3,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int FRAME_DIV        = 1,
    parameter int SERVE_FRAMES     = 60,
    localparam int XW              = $clog2(H_RES),
    localparam int YW              = $clog2(V_RES)
) (
    input  logic          clk_in,
    input  logic          i_rst,
    input  logic          enablePong,
    input  logic          o_active,
    input  logic [XW-1:0] o_x,
    input  logic [YW-1:0] o_y,
    input  logic [YW-1:0] pos_yBarra1,
    input  logic [YW-1:0] pos_yBarra2,
    output logic          pointPlayer1,
    output logic          pointPlayer2,
    output logic          color,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic          serving
);
    localparam int SW   = ((XW > YW) ? XW : YW) + 2;
    localparam int CMAX = (SERVE_FRAMES > FRAME_DIV) ? SERVE_FRAMES : FRAME_DIV;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int HW   = $clog2(HITS_PER_SPEEDUP + 1);

    localparam logic signed [SW-1:0] C_ZERO = SW'(0);
    localparam logic signed [SW-1:0] C_BW1  = SW'(BALL_W - 1);
    localparam logic signed [SW-1:0] C_BH1  = SW'(BALL_H - 1);
    localparam logic signed [SW-1:0] C_BH2  = SW'(BALL_H / 2);
    localparam logic signed [SW-1:0] C_P1_L = SW'(PAD1_X);
    localparam logic signed [SW-1:0] C_P1_R = SW'(PAD1_X + PAD_W - 1);
    localparam logic signed [SW-1:0] C_P2_L = SW'(PAD2_X);
    localparam logic signed [SW-1:0] C_P2_R = SW'(PAD2_X + PAD_W - 1);
    localparam logic signed [SW-1:0] C_PH1  = SW'(PAD_H - 1);
    localparam logic signed [SW-1:0] C_Z1   = SW'(PAD_H / 3);
    localparam logic signed [SW-1:0] C_Z2   = SW'(2 * PAD_H / 3);
    localparam logic signed [SW-1:0] C_DY   = SW'(DY_MAX);
    localparam logic signed [SW-1:0] C_XMAX = SW'(H_RES - BALL_W);
    localparam logic signed [SW-1:0] C_YMAX = SW'(V_RES - BALL_H);
    localparam logic [XW-1:0]        C_CX   = XW'((H_RES - BALL_W) / 2);
    localparam logic [YW-1:0]        C_CY   = YW'((V_RES - BALL_H) / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_SCORE = 2'd3
    } state_t;

    state_t                r_state, w_state_n;
    logic [XW-1:0]         r_ball_x, r_step_x;
    logic [YW-1:0]         r_ball_y;
    logic signed [SW-1:0]  r_dy;
    logic [HW-1:0]         r_hits;
    logic [CW-1:0]         r_frame_cnt;
    logic                  r_dx_left, r_serve_left, r_point1, r_point2, r_color, r_serving;

    logic                  w_ft, w_move, w_enter_serve, w_cor;
    logic                  w_hit1, w_hit2, w_hit, w_goal1, w_goal2, w_dx_left_n, w_hits_wrap;
    logic signed [SW-1:0]  w_bx, w_by, w_p1, w_p2, w_step, w_ox, w_oy;
    logic signed [SW-1:0]  w_yc_raw, w_yc, w_zone_dy, w_dy_n, w_dy_abs, w_nx, w_ny, w_y_wall, w_dy_wall;
    logic [HW-1:0]         w_hits_n;
    logic [XW-1:0]         w_step_n;

    assign w_ft          = (o_x == XW'(H_RES - 1)) && (o_y == YW'(V_RES - 1));
    assign w_move        = (r_state == S_PLAY) && w_ft && (r_frame_cnt == CW'(FRAME_DIV - 1));
    assign w_enter_serve = enablePong && (((r_state == S_IDLE) && w_ft) || (r_state == S_SCORE));

    assign w_bx   = {{(SW-XW){1'b0}}, r_ball_x};
    assign w_by   = {{(SW-YW){1'b0}}, r_ball_y};
    assign w_p1   = {{(SW-YW){1'b0}}, pos_yBarra1};
    assign w_p2   = {{(SW-YW){1'b0}}, pos_yBarra2};
    assign w_step = {{(SW-XW){1'b0}}, r_step_x};
    assign w_ox   = {{(SW-XW){1'b0}}, o_x};
    assign w_oy   = {{(SW-YW){1'b0}}, o_y};

    assign w_cor = o_active && enablePong && (w_ox >= w_bx) && (w_ox <= w_bx + C_BW1)
                   && (w_oy >= w_by) && (w_oy <= w_by + C_BH1);

    // Paddle, goal and wall resolution for one move, all from the pre-move position.
    always_comb begin
        w_yc      = C_ZERO;
        w_zone_dy = C_ZERO;
        w_y_wall  = C_ZERO;
        w_dy_wall = C_ZERO;
        w_hit1 = r_dx_left && (w_bx <= C_P1_R) && (w_bx + C_BW1 >= C_P1_L)
                 && (w_by + C_BH1 >= w_p1) && (w_by <= w_p1 + C_PH1);
        w_hit2 = !r_dx_left && (w_bx <= C_P2_R) && (w_bx + C_BW1 >= C_P2_L)
                 && (w_by + C_BH1 >= w_p2) && (w_by <= w_p2 + C_PH1);
        w_hit  = w_hit1 || w_hit2;
        w_yc_raw = w_by + C_BH2 - (w_hit1 ? w_p1 : w_p2);
        if (w_yc_raw < C_ZERO) w_yc = C_ZERO;
        else if (w_yc_raw > C_PH1) w_yc = C_PH1;
        else w_yc = w_yc_raw;
        if (w_yc < C_Z1) w_zone_dy = -C_DY;
        else if (w_yc < C_Z2) w_zone_dy = C_ZERO;
        else w_zone_dy = C_DY;
        w_dx_left_n = w_hit1 ? 1'b0 : (w_hit2 ? 1'b1 : r_dx_left);
        w_dy_n      = w_hit ? w_zone_dy : r_dy;
        w_goal2     = !w_hit && r_dx_left && (w_bx < w_step);
        w_goal1     = !w_hit && !r_dx_left && (w_bx + w_step > C_XMAX);
        w_nx        = w_dx_left_n ? (w_bx - w_step) : (w_bx + w_step);
        w_ny        = w_by + w_dy_n;
        w_dy_abs    = (w_dy_n < C_ZERO) ? -w_dy_n : w_dy_n;
        if (w_ny <= C_ZERO) begin
            w_y_wall  = C_ZERO;
            w_dy_wall = w_dy_abs;
        end else if (w_ny >= C_YMAX) begin
            w_y_wall  = C_YMAX;
            w_dy_wall = -w_dy_abs;
        end else begin
            w_y_wall  = w_ny;
            w_dy_wall = w_dy_n;
        end
        w_hits_wrap = (r_hits == HW'(HITS_PER_SPEEDUP - 1));
        w_hits_n    = w_hits_wrap ? HW'(0) : r_hits + HW'(1);
        w_step_n    = (w_hits_wrap && (r_step_x < XW'(STEP_X_MAX))) ? r_step_x + XW'(1) : r_step_x;
    end

    // Next-state logic; a low enable overrides every state.
    always_comb begin
        w_state_n = r_state;
        if (!enablePong) begin
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_n = w_ft ? S_SERVE : S_IDLE;
                S_SERVE: w_state_n = (w_ft && (r_frame_cnt == CW'(SERVE_FRAMES - 1))) ? S_PLAY : S_SERVE;
                S_PLAY:  w_state_n = (w_move && (w_goal1 || w_goal2)) ? S_SCORE : S_PLAY;
                S_SCORE: w_state_n = S_SERVE;
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // State register and its registered serve flag.
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_serving <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_serving <= (w_state_n == S_SERVE);
        end
    end

    // Ball position, direction, speed, frame counting and score pulses.
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            r_ball_x     <= C_CX;
            r_ball_y     <= C_CY;
            r_dx_left    <= 1'b0;
            r_dy         <= C_ZERO;
            r_step_x     <= XW'(STEP_X);
            r_hits       <= HW'(0);
            r_frame_cnt  <= CW'(0);
            r_serve_left <= 1'b0;
            r_point1     <= 1'b0;
            r_point2     <= 1'b0;
            r_color      <= 1'b0;
        end else begin
            r_point1 <= 1'b0;
            r_point2 <= 1'b0;
            r_color  <= w_cor;
            if (!enablePong || w_enter_serve) begin
                r_ball_x    <= C_CX;
                r_ball_y    <= C_CY;
                r_dy        <= C_ZERO;
                r_step_x    <= XW'(STEP_X);
                r_hits      <= HW'(0);
                r_frame_cnt <= CW'(0);
                if (w_enter_serve) r_dx_left <= r_serve_left;
            end else if (w_ft && (r_state == S_SERVE)) begin
                r_frame_cnt <= (r_frame_cnt == CW'(SERVE_FRAMES - 1)) ? CW'(0) : r_frame_cnt + CW'(1);
            end else if (w_ft && (r_state == S_PLAY)) begin
                if (!w_move) begin
                    r_frame_cnt <= r_frame_cnt + CW'(1);
                end else begin
                    r_frame_cnt <= CW'(0);
                    if (w_goal1 || w_goal2) begin
                        // The conceding side receives the next serve; ball stays put until SCORE.
                        r_point1     <= w_goal1;
                        r_point2     <= w_goal2;
                        r_serve_left <= w_goal2;
                    end else begin
                        r_ball_x  <= XW'(w_nx);
                        r_ball_y  <= YW'(w_y_wall);
                        r_dx_left <= w_dx_left_n;
                        r_dy      <= w_dy_wall;
                        if (w_hit) begin
                            r_hits   <= w_hits_n;
                            r_step_x <= w_step_n;
                        end
                    end
                end
            end
        end
    end

    assign pointPlayer1 = r_point1;
    assign pointPlayer2 = r_point2;
    assign color        = r_color;
    assign ball_x       = r_ball_x;
    assign ball_y       = r_ball_y;
    assign serving      = r_serving;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized bench for pong_ball_engine against a frame-level game model of the ball rules.
module tb_pong_ball_engine;
    localparam int H_RES = 640, V_RES = 480, BW = 8, BH = 8;
    localparam int PAD_W = 10, PAD_H = 90, PAD1_X = 10, PAD2_X = 620;
    localparam int CX = (H_RES - BW) / 2, CY = (V_RES - BH) / 2;
    localparam int SERVE_FRAMES = 60, FRAME_DIV = 1, NFRAMES = 5000;
    localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_SCORE = 3;

    logic       clk_in = 1'b0;
    logic       i_rst, enablePong, o_active;
    logic [9:0] o_x;
    logic [8:0] o_y, pos_yBarra1, pos_yBarra2;
    logic       pointPlayer1, pointPlayer2, color, serving;
    logic [9:0] ball_x;
    logic [8:0] ball_y;

    pong_ball_engine dut (
        .clk_in(clk_in), .i_rst(i_rst), .enablePong(enablePong), .o_active(o_active),
        .o_x(o_x), .o_y(o_y), .pos_yBarra1(pos_yBarra1), .pos_yBarra2(pos_yBarra2),
        .pointPlayer1(pointPlayer1), .pointPlayer2(pointPlayer2), .color(color),
        .ball_x(ball_x), .ball_y(ball_y), .serving(serving)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0, n_err = 0;
    int mx, my, mdx, mdy, mstep, mhits, mcnt, mphase, m_serve_left;
    int rally_hits, rally_target, exp_p1, exp_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        mphase = PH_IDLE; mx = CX; my = CY; mdx = 1; mdy = 0; mstep = 2; mhits = 0; mcnt = 0;
        m_serve_left = 0; exp_p1 = 0; exp_p2 = 0; rally_hits = 0; rally_target = 0;
    endtask

    task automatic enter_serve();
        mphase = PH_SERVE; mx = CX; my = CY; mcnt = 0; mdy = 0; mstep = 2; mhits = 0;
        mdx = m_serve_left ? -1 : 1;
        rally_hits = 0;
        rally_target = int'($urandom_range(0, 20));
    endtask

    // One ball move under the game rules: paddle first, then goal, then wall.
    task automatic ball_move(input int p1, input int p2);
        int pad, yc, s, ny;
        bit hit;
        s = mstep; hit = 0; pad = 0;
        if (mdx < 0 && mx <= PAD1_X + PAD_W - 1 && mx + BW - 1 >= PAD1_X && my + BH - 1 >= p1 && my <= p1 + PAD_H - 1) begin
            hit = 1; pad = p1;
        end else if (mdx > 0 && mx <= PAD2_X + PAD_W - 1 && mx + BW - 1 >= PAD2_X && my + BH - 1 >= p2 && my <= p2 + PAD_H - 1) begin
            hit = 1; pad = p2;
        end
        if (hit) begin
            yc = my + BH / 2 - pad;
            if (yc < 0) yc = 0;
            if (yc > PAD_H - 1) yc = PAD_H - 1;
            mdy = (yc < PAD_H / 3) ? -3 : ((yc < 2 * PAD_H / 3) ? 0 : 3);
            mdx = -mdx;
            rally_hits++;
            mhits++;
            if (mhits == 4) begin
                mhits = 0;
                if (mstep < 6) mstep++;
            end
        end else if (mdx < 0 && mx < s) begin
            exp_p2 = 1; m_serve_left = 1; mphase = PH_SCORE;
            return;
        end else if (mdx > 0 && mx + s > H_RES - BW) begin
            exp_p1 = 1; m_serve_left = 0; mphase = PH_SCORE;
            return;
        end
        mx = mx + mdx * s;
        ny = my + mdy;
        if (ny <= 0) begin
            my = 0; mdy = (mdy < 0) ? -mdy : mdy;
        end else if (ny >= V_RES - BH) begin
            my = V_RES - BH; mdy = (mdy < 0) ? mdy : -mdy;
        end else begin
            my = ny;
        end
    endtask

    task automatic model_edge(input bit en, input bit ft, input int p1, input int p2);
        exp_p1 = 0; exp_p2 = 0;
        if (!en) begin
            mphase = PH_IDLE; mx = CX; my = CY; mcnt = 0; mdy = 0; mstep = 2; mhits = 0;
        end else begin
            case (mphase)
                PH_IDLE:  if (ft) enter_serve();
                PH_SCORE: enter_serve();
                PH_SERVE: if (ft) begin
                    if (mcnt == SERVE_FRAMES - 1) begin mphase = PH_PLAY; mcnt = 0; end
                    else mcnt++;
                end
                PH_PLAY:  if (ft) begin
                    mcnt++;
                    if (mcnt == FRAME_DIV) begin mcnt = 0; ball_move(p1, p2); end
                end
                default:  mphase = PH_IDLE;
            endcase
        end
    endtask

    // Apply the current inputs for one clock and check every output against the model.
    task automatic apply();
        int ox, oy;
        bit ft, ec;
        ox = int'(o_x); oy = int'(o_y);
        ft = (ox == H_RES - 1) && (oy == V_RES - 1);
        ec = o_active && enablePong && ox >= mx && ox <= mx + BW - 1 && oy >= my && oy <= my + BH - 1;
        model_edge(enablePong, ft, int'(pos_yBarra1), int'(pos_yBarra2));
        @(posedge clk_in); #1;
        chk("ball_x", ball_x, mx);
        chk("ball_y", ball_y, my);
        chk("serving", serving, mphase == PH_SERVE);
        chk("color", color, ec);
        chk("point1", pointPlayer1, exp_p1);
        chk("point2", pointPlayer2, exp_p2);
    endtask

    task automatic rand_pixel();
        int x, y;
        if ($urandom_range(0, 1) == 1) begin
            x = mx - 2 + int'($urandom_range(0, 11));
            y = my - 2 + int'($urandom_range(0, 11));
        end else begin
            x = int'($urandom_range(0, H_RES - 2));
            y = int'($urandom_range(0, V_RES - 1));
        end
        if (x < 0) x = 0;
        if (x > H_RES - 2) x = H_RES - 2;
        if (y < 0) y = 0;
        if (y > V_RES - 1) y = V_RES - 1;
        o_x = 10'(x); o_y = 9'(y);
        o_active = ($urandom_range(0, 4) != 0);
        pos_yBarra1 = 9'($urandom_range(0, V_RES - 1));
        pos_yBarra2 = 9'($urandom_range(0, V_RES - 1));
    endtask

    task automatic set_paddles();
        int r1, r2, a, b;
        if (rally_hits < rally_target) begin
            r1 = int'($urandom_range(0, PAD_H - 1));
            r2 = int'($urandom_range(0, PAD_H - 1));
            a = my + BH / 2 - r1; b = my + BH / 2 - r2;
            if (a < 0) a = 0;
            if (b < 0) b = 0;
        end else begin
            a = (my < 240) ? 380 : 0;
            b = a;
        end
        pos_yBarra1 = 9'(a); pos_yBarra2 = 9'(b);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ball_x"}, ball_x, CX);
        chk({tag, "_ball_y"}, ball_y, CY);
        chk({tag, "_serving"}, serving, 0);
        chk({tag, "_color"}, color, 0);
        chk({tag, "_point1"}, pointPlayer1, 0);
        chk({tag, "_point2"}, pointPlayer2, 0);
    endtask

    initial begin
        int cnt;
        model_reset();
        i_rst = 1'b0; enablePong = 1'b0; o_active = 1'b0;
        o_x = 10'd0; o_y = 9'd0; pos_yBarra1 = 9'd0; pos_yBarra2 = 9'd0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk_in); #1;
        i_rst = 1'b1;

        for (int f = 0; f < 3; f++) begin
            rand_pixel(); apply();
            o_x = 10'(H_RES - 1); o_y = 9'(V_RES - 1); apply();
        end
        enablePong = 1'b1;
        o_x = 10'(H_RES - 1); o_y = 9'(V_RES - 1); o_active = 1'b1; apply();

        // Scan a window around the parked ball, first visible then with the active area off.
        for (int pass = 0; pass < 2; pass++) begin
            cnt = 0;
            for (int yy = CY - 4; yy < CY + 12; yy++) begin
                for (int xx = CX - 4; xx < CX + 12; xx++) begin
                    o_x = 10'(xx); o_y = 9'(yy); o_active = (pass == 0);
                    apply();
                    cnt += int'(color);
                end
            end
            chk(pass == 0 ? "color_count_active" : "color_count_blank", cnt, pass == 0 ? 64 : 0);
        end

        for (int f = 0; f < NFRAMES; f++) begin
            int n;
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                rand_pixel();
                enablePong = ($urandom_range(0, 299) != 0);
                apply();
            end
            enablePong = 1'b1;
            if (f == 2500) begin
                #2 i_rst = 1'b0;
                #1 model_reset();
                check_reset_outputs("midrst");
                @(posedge clk_in); #1;
                check_reset_outputs("midrst_hold");
                i_rst = 1'b1;
            end
            o_x = 10'(H_RES - 1); o_y = 9'(V_RES - 1); o_active = 1'b1;
            set_paddles();
            apply();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
